// File: rtl/letc_core_stage_f.sv
// Fetch stage: issues one word-aligned imem request at a time and hands each fetched word to decode.
// Define LETC_CORE_STAGE_F_ASSERTIONS_EN to compile the simulation protocol assertions.
module letc_core_stage_f #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_imem_req_valid,
    input  logic        i_imem_req_ready,
    output logic [31:0] o_imem_req_addr,
    input  logic        i_imem_rsp_valid,
    input  logic [31:0] i_imem_rsp_data,
    output logic        o_f2d_valid,
    input  logic        i_f2d_ready,
    output logic [31:0] o_f2d_instr,
    output logic [31:0] o_f2d_pc,
    output logic [2:0]  o_dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // valid and its payload stay stable until that edge, and valid never waits on ready.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        HOLD = 3'd3,
        DROP = 3'd4
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] redirect_tgt;
    logic        req_accept;
    logic        unused_pc_bits;

    assign redirect_tgt     = {i_redirect_pc[31:2], 2'b00};
    assign unused_pc_bits   = ^i_redirect_pc[1:0];
    assign req_accept       = (state == REQ) && i_imem_req_ready;
    assign o_imem_req_valid = (state == REQ);
    assign o_imem_req_addr  = pc;
    assign o_dbg_state      = state;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            o_f2d_valid <= 1'b0;
            o_f2d_instr <= 32'h0000_0000;
            o_f2d_pc    <= 32'h0000_0000;
        end else if (i_redirect) begin
            // Redirect beats every other event; a request already accepted leaves a response to drain.
            pc          <= redirect_tgt;
            o_f2d_valid <= 1'b0;
            case (state)
                REQ:       state <= req_accept ? DROP : REQ;
                WAIT,
                DROP:      state <= i_imem_rsp_valid ? REQ : DROP;
                default:   state <= REQ;
            endcase
        end else begin
            case (state)
                IDLE: state <= REQ;
                REQ: begin
                    if (req_accept) state <= WAIT;
                end
                WAIT: begin
                    if (i_imem_rsp_valid) begin
                        o_f2d_instr <= i_imem_rsp_data;
                        o_f2d_pc    <= pc;
                        o_f2d_valid <= 1'b1;
                        pc          <= pc + 32'd4;
                        state       <= HOLD;
                    end
                end
                HOLD: begin
                    if (i_f2d_ready) begin
                        o_f2d_valid <= 1'b0;
                        state       <= REQ;
                    end
                end
                DROP: begin
                    if (i_imem_rsp_valid) state <= REQ;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef LETC_CORE_STAGE_F_ASSERTIONS_EN
    logic        past_req_stall;
    logic        past_f2d_stall;
    logic [31:0] past_addr;
    logic [31:0] past_instr;
    logic [31:0] past_pc;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            past_req_stall <= 1'b0;
            past_f2d_stall <= 1'b0;
            past_addr      <= 32'h0000_0000;
            past_instr     <= 32'h0000_0000;
            past_pc        <= 32'h0000_0000;
        end else begin
            past_req_stall <= (state == REQ) && !i_imem_req_ready && !i_redirect;
            past_f2d_stall <= o_f2d_valid && !i_f2d_ready && !i_redirect;
            past_addr      <= o_imem_req_addr;
            past_instr     <= o_f2d_instr;
            past_pc        <= o_f2d_pc;
        end
    end

    always @(posedge i_clk) begin
        if (i_rst_n) begin
            assert (!(i_imem_rsp_valid && (state != WAIT) && (state != DROP)))
                else $error("imem response outside WAIT/DROP");
            if (past_req_stall)
                assert (o_imem_req_addr == past_addr)
                    else $error("imem address changed while unaccepted");
            if (past_f2d_stall)
                assert (o_f2d_valid && (o_f2d_instr == past_instr) && (o_f2d_pc == past_pc))
                    else $error("f2d payload changed while not accepted");
        end
    end
`endif

endmodule

// File: tb/tb_letc_core_stage_f.sv
// Bench for letc_core_stage_f: directed protocol scenarios, then random traffic against a transaction scoreboard.
module tb_letc_core_stage_f;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_redirect = 1'b0;
    logic [31:0] i_redirect_pc = 32'h0;
    logic        o_imem_req_valid;
    logic        i_imem_req_ready = 1'b0;
    logic [31:0] o_imem_req_addr;
    logic        i_imem_rsp_valid = 1'b0;
    logic [31:0] i_imem_rsp_data = 32'h0;
    logic        o_f2d_valid;
    logic        i_f2d_ready = 1'b0;
    logic [31:0] o_f2d_instr;
    logic [31:0] o_f2d_pc;
    logic [2:0]  o_dbg_state;

    letc_core_stage_f #(.RESET_PC(32'h0000_0000)) dut (
        .i_clk            (i_clk),
        .i_rst_n          (i_rst_n),
        .i_redirect       (i_redirect),
        .i_redirect_pc    (i_redirect_pc),
        .o_imem_req_valid (o_imem_req_valid),
        .i_imem_req_ready (i_imem_req_ready),
        .o_imem_req_addr  (o_imem_req_addr),
        .i_imem_rsp_valid (i_imem_rsp_valid),
        .i_imem_rsp_data  (i_imem_rsp_data),
        .o_f2d_valid      (o_f2d_valid),
        .i_f2d_ready      (i_f2d_ready),
        .o_f2d_instr      (o_f2d_instr),
        .o_f2d_pc         (o_f2d_pc),
        .o_dbg_state      (o_dbg_state)
    );

    always #5 i_clk = ~i_clk;

    int          total = 0;
    int          bad = 0;
    int          delivered = 0;
    bit          model_on = 1'b0;
    bit          spur = 1'b0;
    int          mem_delay = 0;
    logic [31:0] mem_addr_q[$];
    int          mem_cnt_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] next_fetch;
    bit          prev_hold = 1'b0;
    logic [31:0] prev_instr;
    logic [31:0] prev_pc;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h0000_0013;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock cycle: memory response, scoreboard update for this edge, then sample #1 after the edge.
    task automatic tick();
        logic accept;
        logic hshake;
        logic [31:0] head;
        if (model_on && prev_hold) begin
            check("hold_valid", {31'b0, o_f2d_valid}, 32'd1);
            check("hold_instr", o_f2d_instr, prev_instr);
            check("hold_pc", o_f2d_pc, prev_pc);
        end
        i_imem_rsp_valid = 1'b0;
        i_imem_rsp_data  = 32'h0;
        if (spur) begin
            i_imem_rsp_valid = 1'b1;
            i_imem_rsp_data  = 32'hDEAD_BEEF;
        end else if (mem_addr_q.size() > 0) begin
            if (mem_cnt_q[0] == 0) begin
                i_imem_rsp_valid = 1'b1;
                i_imem_rsp_data  = mem_word(mem_addr_q[0]);
                void'(mem_addr_q.pop_front());
                void'(mem_cnt_q.pop_front());
            end else begin
                mem_cnt_q[0] = mem_cnt_q[0] - 1;
            end
        end
        accept = o_imem_req_valid && i_imem_req_ready && i_rst_n;
        hshake = o_f2d_valid && i_f2d_ready && i_rst_n;
        if (model_on) begin
            if (accept) begin
                check("one_outstanding", mem_addr_q.size(), 0);
                check("fetch_addr", o_imem_req_addr, next_fetch);
                exp_q.push_back(o_imem_req_addr);
                next_fetch = o_imem_req_addr + 32'd4;
            end
            if (hshake) begin
                delivered++;
                if (exp_q.size() == 0) begin
                    check("unexpected_deliver", o_f2d_pc, 32'hFFFF_FFFF);
                end else begin
                    head = exp_q.pop_front();
                    check("deliver_pc", o_f2d_pc, head);
                    check("deliver_instr", o_f2d_instr, mem_word(head));
                end
            end
            if (i_redirect) begin
                exp_q.delete();
                next_fetch = {i_redirect_pc[31:2], 2'b00};
            end
        end
        if (accept) begin
            mem_addr_q.push_back(o_imem_req_addr);
            mem_cnt_q.push_back(model_on ? int'($urandom_range(0, 3)) : mem_delay);
        end
        prev_hold  = o_f2d_valid && !i_f2d_ready && !i_redirect;
        prev_instr = o_f2d_instr;
        prev_pc    = o_f2d_pc;
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        i_rst_n          = 1'b0;
        i_redirect       = 1'b0;
        i_imem_req_ready = 1'b0;
        i_f2d_ready      = 1'b0;
        i_imem_rsp_valid = 1'b0;
        mem_addr_q.delete();
        mem_cnt_q.delete();
        exp_q.delete();
        next_fetch = 32'h0000_0000;
        prev_hold  = 1'b0;
        #1;
        check("rst_req_valid", {31'b0, o_imem_req_valid}, 32'd0);
        check("rst_req_addr", o_imem_req_addr, 32'h0000_0000);
        check("rst_f2d_valid", {31'b0, o_f2d_valid}, 32'd0);
        check("rst_f2d_instr", o_f2d_instr, 32'h0);
        check("rst_f2d_pc", o_f2d_pc, 32'h0);
        repeat (2) @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
    endtask

    initial begin
        do_reset();

        // First fetch after reset and its latency.
        i_imem_req_ready = 1'b1;
        mem_delay = 0;
        tick();
        check("first_req_valid", {31'b0, o_imem_req_valid}, 32'd1);
        check("first_req_addr", o_imem_req_addr, 32'h0000_0000);
        tick();
        check("lat_early_valid", {31'b0, o_f2d_valid}, 32'd0);
        check("wait_no_req", {31'b0, o_imem_req_valid}, 32'd0);
        tick();
        check("first_f2d_valid", {31'b0, o_f2d_valid}, 32'd1);
        check("first_f2d_instr", o_f2d_instr, 32'h0000_0013);
        check("first_f2d_pc", o_f2d_pc, 32'h0000_0000);

        // Decode stall, with a stray response that must be ignored.
        for (int i = 0; i < 5; i++) begin
            spur = (i == 2);
            tick();
            check("stall_valid", {31'b0, o_f2d_valid}, 32'd1);
            check("stall_instr", o_f2d_instr, 32'h0000_0013);
            check("stall_pc", o_f2d_pc, 32'h0000_0000);
            check("stall_no_req", {31'b0, o_imem_req_valid}, 32'd0);
        end
        spur = 1'b0;
        i_f2d_ready = 1'b1;
        tick();
        i_f2d_ready = 1'b0;
        check("consume_clear", {31'b0, o_f2d_valid}, 32'd0);
        check("next_req_valid", {31'b0, o_imem_req_valid}, 32'd1);
        check("next_req_addr", o_imem_req_addr, 32'h0000_0004);

        // Redirect while waiting: in-flight response is dropped.
        mem_delay = 2;
        tick();
        i_redirect = 1'b1;
        i_redirect_pc = 32'h0000_1003;
        tick();
        i_redirect = 1'b0;
        check("drop_no_req", {31'b0, o_imem_req_valid}, 32'd0);
        check("drop_no_f2d", {31'b0, o_f2d_valid}, 32'd0);
        tick();
        check("drop_wait_no_f2d", {31'b0, o_f2d_valid}, 32'd0);
        tick();
        check("redir_req_valid", {31'b0, o_imem_req_valid}, 32'd1);
        check("redir_req_addr", o_imem_req_addr, 32'h0000_1000);
        check("redir_no_f2d", {31'b0, o_f2d_valid}, 32'd0);
        mem_delay = 0;
        tick();
        tick();
        check("redir_f2d_valid", {31'b0, o_f2d_valid}, 32'd1);
        check("redir_f2d_pc", o_f2d_pc, 32'h0000_1000);
        check("redir_f2d_instr", o_f2d_instr, mem_word(32'h0000_1000));

        // Redirect in HOLD to the top word, then wrap.
        i_redirect = 1'b1;
        i_redirect_pc = 32'hFFFF_FFFC;
        tick();
        i_redirect = 1'b0;
        check("hold_redir_clear", {31'b0, o_f2d_valid}, 32'd0);
        check("top_req_addr", o_imem_req_addr, 32'hFFFF_FFFC);
        tick();
        tick();
        check("top_f2d_pc", o_f2d_pc, 32'hFFFF_FFFC);
        i_f2d_ready = 1'b1;
        tick();
        i_f2d_ready = 1'b0;
        check("wrap_req_valid", {31'b0, o_imem_req_valid}, 32'd1);
        check("wrap_req_addr", o_imem_req_addr, 32'h0000_0000);

        // Memory stall, then redirect during the stall.
        i_imem_req_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("mstall_valid", {31'b0, o_imem_req_valid}, 32'd1);
            check("mstall_addr", o_imem_req_addr, 32'h0000_0000);
        end
        i_redirect = 1'b1;
        i_redirect_pc = 32'h0000_2000;
        tick();
        i_redirect = 1'b0;
        check("mstall_redir_valid", {31'b0, o_imem_req_valid}, 32'd1);
        check("mstall_redir_addr", o_imem_req_addr, 32'h0000_2000);
        i_imem_req_ready = 1'b1;
        mem_delay = 3;
        tick();
        check("pre_reset_wait", {31'b0, o_imem_req_valid}, 32'd0);

        // Reset while waiting abandons the request.
        do_reset();
        tick();
        check("post_rst_req_valid", {31'b0, o_imem_req_valid}, 32'd1);
        check("post_rst_req_addr", o_imem_req_addr, 32'h0000_0000);
        i_imem_req_ready = 1'b0;
        i_f2d_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("post_rst_no_f2d", {31'b0, o_f2d_valid}, 32'd0);
        end

        // Random traffic against the scoreboard.
        do_reset();
        model_on = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            i_imem_req_ready = ($urandom_range(0, 3) != 0);
            i_f2d_ready      = ($urandom_range(0, 2) != 0);
            i_redirect       = ($urandom_range(0, 11) == 0);
            i_redirect_pc    = $urandom;
            tick();
        end
        i_redirect = 1'b0;
        model_on = 1'b0;
        check("progress", {31'b0, (delivered > 100)}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/letc_core_stage_f.md
LETC_CORE_STAGE_F -- requirements
Module: letc_core_stage_f

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, fetch address issued first after reset.
REQ-002 i_clk  input  1  core clock; all state updates on rising edge.
REQ-003 i_rst_n  input  1  reset; asynchronous, active-low.
REQ-004 i_redirect  input  1  redirect fetch (branch/jump/trap).
REQ-005 i_redirect_pc  input  32  redirect target; bits [1:0] ignored, forced to 0.
REQ-006 o_imem_req_valid  output  1  instruction memory request valid.
REQ-007 i_imem_req_ready  input  1  memory accepts request when high with valid.
REQ-008 o_imem_req_addr  output  32  word-aligned fetch address.
REQ-009 i_imem_rsp_valid  input  1  response data valid (one pulse per accepted request).
REQ-010 i_imem_rsp_data  input  32  fetched instruction word.
REQ-011 o_f2d_valid  output  1  instruction valid toward decode stage.
REQ-012 i_f2d_ready  input  1  decode accepts when high with valid.
REQ-013 o_f2d_instr  output  32  instruction to decode.
REQ-014 o_f2d_pc  output  32  PC of o_f2d_instr.

Function
REQ-015 FSM states SHALL be IDLE, REQ, WAIT, HOLD, DROP; o_imem_req_valid = (state==REQ), o_imem_req_addr = pc register.
REQ-016 At most one imem request SHALL be outstanding at any time.
REQ-017 IDLE -> REQ unconditionally on the next clock.
REQ-018 REQ: request accepted (valid & ready) -> WAIT; otherwise stay REQ with address held stable.
REQ-019 WAIT: i_imem_rsp_valid -> capture data into o_f2d_instr, pc into o_f2d_pc, set o_f2d_valid, pc <= pc+4, -> HOLD.
REQ-020 Latency: response at cycle M SHALL give o_f2d_valid high at cycle M+1.
REQ-021 HOLD: o_f2d_valid/instr/pc held stable until i_f2d_ready; on handshake clear o_f2d_valid, -> REQ.
REQ-022 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-023 Redirect SHALL have priority over all other events: pc <= {i_redirect_pc[31:2],2'b00}, o_f2d_valid cleared next cycle.
REQ-024 Redirect in WAIT, or in REQ in the same cycle the request is accepted -> DROP (response in flight is discarded); redirect in REQ without acceptance -> stay REQ, new address next cycle (only permitted unaccepted address change).
REQ-025 Redirect in HOLD or IDLE -> REQ; a simultaneous decode handshake is still honoured by decode, instruction considered consumed.
REQ-026 DROP: i_imem_rsp_valid -> data discarded, -> REQ; redirect in DROP updates pc, stays DROP unless rsp arrives same cycle (then REQ).
REQ-027 Redirect coincident with response in WAIT -> response discarded, -> REQ.
REQ-028 i_imem_rsp_valid in IDLE, REQ or HOLD SHALL be ignored.

Reset
REQ-029 While i_rst_n low: state IDLE, pc RESET_PC, o_imem_req_valid 0, o_f2d_valid 0, o_f2d_instr 0, o_f2d_pc 0.
REQ-030 Reset asserted mid-transaction SHALL abandon any outstanding request; no response is forwarded afterwards until a new request is accepted.

Configuration
REQ-031 Macro LETC_CORE_STAGE_F_ASSERTIONS_EN defined: simulation assertions SHALL fire on rsp_valid outside WAIT/DROP, o_imem_req_addr change while unaccepted without preceding redirect, and o_f2d_* change while valid and not ready.
REQ-032 Macro undefined: no assertion logic compiled; functional behaviour identical.

Verification
REQ-033 Reset release, ready=1, rsp 1 cycle later with 32'h0000_0013 -> req addr RESET_PC at cycle 1, o_f2d_valid with instr 32'h13, pc 0 at cycle 3.
REQ-034 i_f2d_ready=0 for 5 cycles in HOLD -> o_f2d_* stable, no new imem request; ready=1 -> next request addr 0x4.
REQ-035 Redirect to 32'h0000_1003 while WAIT -> in-flight response dropped, next request addr 32'h0000_1000, never forwarded to decode.
REQ-036 pc = 32'hFFFF_FFFC fetched -> next request addr 32'h0000_0000.
REQ-037 i_imem_req_ready=0 for 4 cycles -> valid held, addr stable; redirect during stall -> address changes to target next cycle.
REQ-038 Reset asserted in WAIT, then released -> outputs at reset values, first request at RESET_PC.
